// File: rtl/event_encoder_if.sv
// Handshake bundle between the event encoder and the code consumer.
// The encoder presents code/valid, the consumer answers with ready.
interface event_encoder_if #(
    parameter int CODE_W = 3
);
    logic [CODE_W-1:0] code;
    logic              valid;
    logic              ready;

    modport master (output code, output valid, input ready);
    modport slave  (input code, input valid, output ready);
endinterface

// File: rtl/event_encoder.sv
// 8-to-3 event encoder: captures request lines into a pending register and
// emits one binary index per accepted transfer, in fixed priority order.
module event_encoder #(
    parameter int N_IN     = 8,
    parameter int CODE_W   = 3,
    parameter int HI_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear,
    input  logic [N_IN-1:0]   req,
    output logic [N_IN-1:0]   pending,
    output logic              dropped,
    event_encoder_if.master   bus
);

    logic              load;
    logic              any_pending;
    logic [CODE_W-1:0] sel_idx;
    logic [N_IN-1:0]   clr_mask;
    logic [N_IN-1:0]   cap;

    // A new code may enter the output stage when it is empty or being drained.
    assign load        = !bus.valid || bus.ready;
    assign any_pending = |pending;
    assign cap         = enable ? req : '0;

    // Priority select over the registered pending snapshot, never same-cycle req.
    always_comb begin
        // NOTE: default first so no path leaves sel_idx unassigned (no latch).
        sel_idx = '0;
        if (HI_FIRST == 0) begin
            // Scan downwards so the lowest set bit is the last one written.
            for (int i = N_IN - 1; i >= 0; i--) begin
                if (pending[i]) sel_idx = CODE_W'(i);
            end
        end else begin
            // Scan upwards so the highest set bit is the last one written.
            for (int i = 0; i < N_IN; i++) begin
                if (pending[i]) sel_idx = CODE_W'(i);
            end
        end
    end

    // One-hot of the bit handed to the output stage this cycle, else nothing.
    always_comb begin
        clr_mask = '0;
        if (load && any_pending) clr_mask = N_IN'(1) << sel_idx;
    end

    // Pending register, coalesce flag and output stage.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            pending   <= '0;
            dropped   <= 1'b0;
            bus.code  <= '0;
            bus.valid <= 1'b0;
        end else if (clear) begin
            pending   <= '0;
            dropped   <= 1'b0;
            bus.code  <= '0;
            bus.valid <= 1'b0;
        end else begin
            // Set wins: a request on the bit being handed out re-arms it.
            pending <= (pending & ~clr_mask) | cap;
            dropped <= |(cap & pending & ~clr_mask);
            if (load) begin
                if (any_pending) begin
                    bus.code  <= sel_idx;
                    bus.valid <= 1'b1;
                end else begin
                    // Code keeps its last value; only valid drops.
                    bus.valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/event_encoder.md
Name: event_encoder

Overview:
- 8-to-3 encoding partner of the team's 3-to-8 decoder: turns request lines back into a binary index.
- Captures requests into a pending register, then emits one 3-bit code per accepted transfer, in fixed priority order, over a valid/ready interface.
- Sits between event sources (one line per source) and a consumer that drives the 3-to-8 decoder.
- Code mapping is the inverse of the decoder: bit k of req produces code = k (bit0 -> 3'b000, bit7 -> 3'b111).

Parameters:
- N_IN, 8, number of request lines; must equal 2**CODE_W.
- CODE_W, 3, width of the output code.
- HI_FIRST, 0, priority order: 0 = lowest set index wins, 1 = highest set index wins.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  when 1, req bits are captured; when 0, req is ignored and pending bits still drain.
- clear  input  1  synchronous flush of pending bits and output stage.
- req  input  N_IN  request lines, sampled every cycle, level or pulse.
- code  output  CODE_W  encoded index of the presented event.
- valid  output  1  code is valid.
- ready  input  1  consumer accepts code when valid && ready.
- pending  output  N_IN  current pending register (registered).
- dropped  output  1  one-cycle pulse: a req bit arrived while the same bit was already pending and not cleared this cycle.

Behaviour:
- Reset (rst=1 at clk edge): pending=0, code=0, valid=0, dropped=0. rst has priority over clear; clear has priority over everything else.
- clear=1: same register values as reset, but for one cycle only; req in that cycle is discarded.
- Capture: cap = enable ? req : 0.
- Pending update: pending_next = (pending & ~clr_mask) | cap.
  - clr_mask is the one-hot bit selected for loading this cycle, else 0.
  - Set wins: a req bit equal to the bit being cleared re-arms it and yields a second event later.
- Dropped: dropped_next = |(cap & pending & ~clr_mask); asserted for exactly one cycle.
- Output stage load condition: load = !valid || ready.
- When load and pending != 0:
  - select idx = lowest set bit of pending (HI_FIRST=0) or highest set bit (HI_FIRST=1); the select uses registered pending, not same-cycle req;
  - code <= idx, valid <= 1, clr_mask = one-hot(idx).
- When load and pending == 0: valid <= 0, code holds its last value.
- When valid && !ready: code, valid and the pending bit already removed are held stable; no new selection; req keeps accumulating.
- Latency:
  - req seen at edge N -> pending bit set after edge N -> valid/code after edge N+1, i.e. 2 cycles when idle.
  - Back-to-back with ready=1: one code per cycle, no bubbles while pending != 0.
- Throughput: at most one code per cycle. Simultaneous req bits are serialised in priority order. Repeated req of an already-pending bit is coalesced into one event and flagged by dropped.
- enable deasserted mid-operation: already-pending bits and the current output still complete normally.
- Starvation is allowed by design: a continuously re-asserted high-priority bit can block lower bits.
- Output ordering is fully determined by the pending snapshot at each load cycle.

Test Plan:
- Reset: drive rst=1 with req=8'hFF, enable=1, then rst=0 with req=0 -> pending=0, valid=0, code=0, dropped=0 during reset; no spurious output afterwards.
- Single event: req=8'b0010_0000 for one cycle, enable=1, ready=1 -> valid=1, code=3'b101 exactly 2 cycles later for one cycle; pending returns to 0.
- Multi-bit ordering, HI_FIRST=0: req=8'b1000_0101 one cycle, ready=1 -> codes 0, 2, 7 on three consecutive cycles. Repeat with HI_FIRST=1 -> codes 7, 2, 0.
- Backpressure: as the multi-bit case but ready=0 for 4 cycles after valid rises -> code=0 held stable with valid=1; after ready=1, codes 2 then 7 follow with no loss.
- Coalesce/dropped: req bit3 on cycle N and N+1 while ready=0 -> dropped pulses 1 cycle; only one code 3 is emitted. Set-wins check: req bit3 on the same cycle bit3 is selected -> code 3 is emitted twice.
- enable/clear: req=8'hFF with enable=0 -> no output. Load 8'hF0, then assert clear mid-drain -> next cycle valid=0, pending=0, and no further codes.
